// File: rtl/vision_pkg.sv
// vision_pkg: types shared by the frame coordinate pipeline.
// Holds the tracker FSM states and the default coordinate type.
package vision_pkg;

  localparam int VIS_COORD_W = 16;

  typedef logic [VIS_COORD_W-1:0] coord_t;

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } trk_state_e;

endpackage

// File: rtl/xy_wrap_counter.sv
// xy_wrap_counter: raster x/y position with line and frame wrap.
// i_clr restarts the raster so the current beat is treated as (0,0).
module xy_wrap_counter #(
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480,
  parameter int COORD_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_adv,
  input  logic               i_clr,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_eol,
  output logic               o_eop,
  output logic               o_home
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(LINE_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(ROW_NUMBER - 1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  // o_x/o_y are the coordinates the current beat is tagged with
  assign w_x    = i_clr ? '0 : r_x;
  assign w_y    = i_clr ? '0 : r_y;
  assign o_x    = w_x;
  assign o_y    = w_y;
  assign o_eol  = (w_x == LAST_X);
  assign o_eop  = o_eol && (w_y == LAST_Y);
  assign o_home = (r_x == '0) && (r_y == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (o_eol) begin
        r_x <= '0;
        r_y <= o_eop ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

endmodule

// File: rtl/frame_coord_tracker.sv
// frame_coord_tracker: tags a pixel stream with x/y and sop/eol/eop.
// Define FRAME_COORD_TRACKER_FRAME_CNT_EN to build the frame counter.
module frame_coord_tracker
  import vision_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480,
  parameter int COORD_W    = 16,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sop,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               sop,
  output logic               eol,
  output logic               eop,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               resync_err
);

  trk_state_e         r_state;
  logic               r_out_valid;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_sop;
  logic               r_eol;
  logic               r_eop;
  logic               r_resync;

  logic               w_acc;
  logic               w_emit;
  logic               w_clr;
  logic               w_resync;
  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;
  logic               w_ceol;
  logic               w_ceop;
  logic               w_home;

  assign in_ready = !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  // beats before the first sop are swallowed while searching
  assign w_emit   = w_acc && (in_sop || (r_state == RUN));
  assign w_clr    = w_acc && in_sop;
  assign w_resync = w_clr && (r_state == RUN) && !w_home;

  xy_wrap_counter #(
    .LINE_WIDTH (LINE_WIDTH),
    .ROW_NUMBER (ROW_NUMBER),
    .COORD_W    (COORD_W)
  ) u_xy (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (w_emit),
    .i_clr  (w_clr),
    .o_x    (w_cx),
    .o_y    (w_cy),
    .o_eol  (w_ceol),
    .o_eop  (w_ceop),
    .o_home (w_home)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sop       <= 1'b0;
      r_eol       <= 1'b0;
      r_eop       <= 1'b0;
      r_resync    <= 1'b0;
    end else begin
      r_resync <= w_resync;
      unique case (r_state)
        SEARCH: if (w_clr) r_state <= RUN;
        RUN:    r_state <= RUN;
        default: r_state <= SEARCH;
      endcase
      if (in_ready) begin
        r_out_valid <= w_emit;
        if (w_emit) begin
          r_x   <= w_cx;
          r_y   <= w_cy;
          r_sop <= (w_cx == '0) && (w_cy == '0);
          r_eol <= w_ceol;
          r_eop <= w_ceop;
        end
      end
    end
  end

`ifdef FRAME_COORD_TRACKER_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  // a frame completes when its last pixel leaves downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (r_out_valid && out_ready && r_eop) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign out_valid  = r_out_valid;
  assign x          = r_x;
  assign y          = r_y;
  assign sop        = r_sop;
  assign eol        = r_eol;
  assign eop        = r_eop;
  assign resync_err = r_resync;

endmodule
